// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin selection among functional units that
// have finished an instruction, with the winner registered onto the CDB one
// cycle later. The CDB also drives the register-file write port.
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*IDX_W-1:0]    req_idx,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      cdb_valid,
  output logic [IDX_W-1:0]          cdb_idx,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      rf_we,
  output logic [15:0]               bcast_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  nxt_ptr;
  // One extra bit so rr_ptr + offset can exceed N_REQ before the modulo fold.
  logic [PTR_W:0]    cand;
  logic              found;
  logic [IDX_W-1:0]  sel_idx;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  // Grant the first requester at or after rr_ptr, wrapping modulo N_REQ;
  // reset kills the grant immediately, even mid-cycle.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) begin
        cand = cand - (PTR_W+1)'(N_REQ);
      end
      if (!found && req[cand[PTR_W-1:0]]) begin
        grant[cand[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    if (reset) begin
      grant = '0;
    end
  end

  // Select the granted unit's fields and the pointer that follows it.
  always_comb begin
    sel_idx  = '0;
    sel_tag  = '0;
    sel_data = '0;
    nxt_ptr  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant[j]) begin
        sel_idx  = req_idx[j*IDX_W +: IDX_W];
        sel_tag  = req_tag[j*TAG_W +: TAG_W];
        sel_data = req_data[j*DATA_W +: DATA_W];
        nxt_ptr  = (j == N_REQ-1) ? '0 : PTR_W'(j+1);
      end
    end
  end

  // Register the winner onto the CDB; without a winner the payload holds and
  // only the valid drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_idx   <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      rr_ptr    <= '0;
      bcast_cnt <= '0;
    end else if (|grant) begin
      cdb_valid <= 1'b1;
      cdb_idx   <= sel_idx;
      cdb_tag   <= sel_tag;
      cdb_data  <= sel_data;
      rr_ptr    <= nxt_ptr;
      bcast_cnt <= bcast_cnt + 16'd1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

  // Index 0 is a real register, so the write enable is never gated by payload.
  assign rf_we = cdb_valid;

endmodule
